// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and the
// single-cycle result/flag evaluator used by alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_NOT    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SLT    = 4'd6;
    localparam logic [3:0] OP_EQ     = 4'd7;
    localparam logic [3:0] OP_SLTU   = 4'd8;
    localparam logic [3:0] OP_SLL    = 4'd9;
    localparam logic [3:0] OP_SRL    = 4'd10;
    localparam logic [3:0] OP_SRA    = 4'd11;
    localparam logic [3:0] OP_MUL    = 4'd12;
    localparam logic [3:0] OP_RSV_LO = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Result is carried at the maximum legal width (64); bits above the
    // operating width are always zero.
    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic        overflow;
        logic        carry;
        logic        illegal;
    } alu_res_t;

    // Evaluates every single-cycle opcode at operating width w (4..64) with
    // shift amounts taken from the low shw bits of b. OP_MUL returns zeros;
    // the iterative engine supplies its result.
    function automatic alu_res_t alu_eval(input logic [63:0] a_in,
                                          input logic [63:0] b_in,
                                          input logic [3:0]  mode,
                                          input int unsigned w,
                                          input int unsigned shw);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] bx;
        logic [63:0] sext;
        logic [64:0] sum;
        logic [6:0]  wi;
        logic [6:0]  amt_mask;
        logic [6:0]  amt;
        logic        add_sel;
        logic        sum_msb;
        logic        ovf;
        logic        cry;
        alu_res_t    r;

        wi       = w[6:0];
        mask     = (w >= 64) ? '1 : ((64'd1 << wi) - 64'd1);
        a        = a_in & mask;
        b        = b_in & mask;
        // Subtraction and compares are A + ~B + 1, so one adder serves all.
        add_sel  = (mode == OP_ADD);
        bx       = add_sel ? b : (~b & mask);
        sum      = {1'b0, a} + {1'b0, bx} + {64'd0, ~add_sel};
        cry      = sum[wi];
        sum_msb  = sum[wi - 7'd1];
        ovf      = (a[wi - 7'd1] == bx[wi - 7'd1]) && (sum_msb != a[wi - 7'd1]);
        amt_mask = (7'd1 << shw[2:0]) - 7'd1;
        amt      = {1'b0, b[5:0]} & amt_mask;
        sext     = a | (a[wi - 7'd1] ? ~mask : 64'd0);

        r = '0;
        case (mode)
            OP_ADD, OP_SUB: begin
                r.result   = sum[63:0] & mask;
                r.overflow = ovf;
                r.carry    = cry;
            end
            OP_NOT: r.result = ~a & mask;
            OP_AND: r.result = a & b;
            OP_OR:  r.result = a | b;
            OP_XOR: r.result = a ^ b;
            OP_SLT: begin
                r.result   = {63'd0, sum_msb ^ ovf};
                r.overflow = ovf;
                r.carry    = cry;
            end
            OP_EQ:  r.result = {63'd0, a == b};
            OP_SLTU: begin
                r.result = {63'd0, ~cry};
                r.carry  = cry;
            end
            OP_SLL: r.result = (amt >= wi) ? 64'd0 : ((a << amt) & mask);
            OP_SRL: r.result = (amt >= wi) ? 64'd0 : (a >> amt);
            OP_SRA: begin
                if (amt >= wi) begin
                    r.result = a[wi - 7'd1] ? mask : 64'd0;
                end else begin
                    r.result = ($signed(sext) >>> amt) & mask;
                end
            end
            OP_MUL: r.result = 64'd0;
            default: begin
                r.result  = 64'd0;
                r.illegal = 1'b1;
            end
        endcase
        r.zero = (r.result == 64'd0);
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result bus of the sequential ALU.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid && !ready, and valid
// never drops without a transfer.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             illegal;
    state_t           state;

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry, illegal, state
    );

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry, illegal, state
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per
// product. done pulses for one cycle once prod holds the final value.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Load on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and valid/ready on both sides.
// Single-cycle opcodes complete on the accept edge; mul runs the iterative
// engine for WIDTH cycles before the result is presented.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    alu_res_t           ev;

    assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_HOLD && bus.out_ready);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.state     = state_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.mode == OP_MUL);
    assign ev            = alu_eval(64'(bus.a), 64'(bus.b), bus.mode, WIDTH, SHW);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: HOLD accepts a new op in the same cycle its result drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? S_MUL : S_HOLD;
                end
            end
            S_MUL: begin
                if (mul_done && !mul_busy) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    state_d = is_mul ? S_MUL : S_HOLD;
                end else if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result/flag registers: loaded on a single-cycle accept or at mul completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.carry    <= 1'b0;
            bus.illegal  <= 1'b0;
        end else if (accept && !is_mul) begin
            bus.result   <= ev.result[WIDTH-1:0];
            bus.zero     <= ev.zero;
            bus.overflow <= ev.overflow;
            bus.carry    <= ev.carry;
            bus.illegal  <= ev.illegal;
        end else if (state_q == S_MUL && mul_done) begin
            bus.result   <= mul_prod[WIDTH-1:0];
            bus.zero     <= (mul_prod[WIDTH-1:0] == '0);
            bus.overflow <= 1'b0;
            bus.carry    <= |mul_prod[2*WIDTH-1:WIDTH];
            bus.illegal  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: reset, back-to-back single-cycle
// ops, shifts, multiply latency and abort, backpressure and reserved opcodes.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [3:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;   // {zero, overflow, carry, illegal}
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [11:0] exp_q[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] obs_flags();
        return {bus.zero, bus.overflow, bus.carry, bus.illegal};
    endfunction

    task automatic drive(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.mode     = mode;
        bus.a        = a;
        bus.b        = b;
    endtask

    // Called at a negedge; the op is accepted on the next rising edge and its
    // result is checked at the following negedge, so calls chain back-to-back.
    task automatic issue_vec(input string tag, input vec_t v);
        logic [11:0] e;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        drive(v.mode, v.a, v.b);
        exp_q.push_back({v.flg, v.res});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(e[7:0]));
        check({tag, "_flags"}, 64'(obs_flags()), 64'(e[11:8]));
    endtask

    task automatic go_idle(input string tag);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] res, input logic [3:0] flg);
        int   lat;
        logic ir_bad;
        drive(OP_MUL, a, b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom_range(0, 255));
        bus.b        = 8'($urandom_range(0, 255));
        lat    = 0;
        ir_bad = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.in_ready) ir_bad = 1'b1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_in_ready_busy"}, 64'(ir_bad), 64'd0);
        check({tag, "_result"}, 64'(bus.result), 64'(res));
        check({tag, "_flags"}, 64'(obs_flags()), 64'(flg));
    endtask

    vec_t arith_v[7];
    vec_t shift_v[5];
    vec_t rsv_v[5];

    initial begin
        int   seen_valid;

        arith_v[0] = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0100};
        arith_v[1] = '{OP_SUB,  8'h05, 8'h05, 8'h00, 4'b1010};
        arith_v[2] = '{OP_SLT,  8'h80, 8'h01, 8'h01, 4'b0110};
        arith_v[3] = '{OP_SLTU, 8'h80, 8'h01, 8'h00, 4'b1010};
        arith_v[4] = '{OP_NOT,  8'h0F, 8'h00, 8'hF0, 4'b0000};
        arith_v[5] = '{OP_AND,  8'hCC, 8'hAA, 8'h88, 4'b0000};
        arith_v[6] = '{OP_EQ,   8'h5A, 8'h5A, 8'h01, 4'b0000};

        shift_v[0] = '{OP_SRA, 8'h90, 8'h03, 8'hF2, 4'b0000};
        shift_v[1] = '{OP_SRL, 8'h90, 8'h03, 8'h12, 4'b0000};
        shift_v[2] = '{OP_SLL, 8'h01, 8'h07, 8'h80, 4'b0000};
        shift_v[3] = '{OP_SLL, 8'h01, 8'h08, 8'h01, 4'b0000};
        shift_v[4] = '{OP_SRA, 8'h90, 8'h07, 8'hFF, 4'b0000};

        rsv_v[0] = '{4'd14,  8'h55, 8'h33, 8'h00, 4'b1001};
        rsv_v[1] = '{OP_OR,  8'h01, 8'h02, 8'h03, 4'b0000};
        rsv_v[2] = '{4'd13,  8'hFF, 8'hFF, 8'h00, 4'b1001};
        rsv_v[3] = '{4'd15,  8'h01, 8'h01, 8'h00, 4'b1001};
        rsv_v[4] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010};

        tests_run    = 0;
        tests_failed = 0;

        // Reset.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'(obs_flags()), 64'd0);
        check("rst_state", 64'(bus.state), 64'(S_IDLE));

        // Back-to-back single-cycle ops.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) issue_vec($sformatf("arith%0d", i), arith_v[i]);
        for (int i = 0; i < 5; i++) issue_vec($sformatf("shift%0d", i), shift_v[i]);
        go_idle("arith");

        // Multiply, then abort one mid-flight.
        run_mul("mul0", 8'h13, 8'h0D, 8'hF7, 4'b0000);
        run_mul("mul1", 8'h20, 8'h10, 8'h00, 4'b1010);
        drive(OP_MUL, 8'h13, 8'h0D);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", 64'(bus.state), 64'(S_IDLE));
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_result", 64'(bus.result), 64'd0);
        rst_n      = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        check("abort_no_result", 64'(seen_valid), 64'd0);

        // Backpressure: a held add while a xor is already offered.
        bus.out_ready = 1'b0;
        drive(OP_ADD, 8'h03, 8'h04);
        @(posedge clk);
        #1;
        drive(OP_XOR, 8'hF0, 8'hFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold_result%0d", k), 64'(bus.result), 64'h07);
            check($sformatf("bp_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_xor_result", 64'(bus.result), 64'h0F);
        check("bp_xor_valid", 64'(bus.out_valid), 64'd1);
        go_idle("bp");

        // Reserved opcodes and recovery.
        for (int i = 0; i < 5; i++) issue_vec($sformatf("rsv%0d", i), rsv_v[i]);
        go_idle("rsv");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
